// File: rtl/mem_arbiter.sv
// Arbitrates the MIPS core's instruction-fetch and data requesters onto one RAM port.
// D has priority, a starvation counter guarantees I progress, and a watchdog bounds every transaction.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int TM_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [TM_W-1:0] TMO_LIM    = TM_W'(TIMEOUT);
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, ISERV = 2'd1, DSERV = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [TM_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            mem_err_q, mem_err_d;

  logic dreq, in_serv, own_req, access, fault, done;

  // Completion, error and abort are only meaningful for the requester currently owning the port.
  always_comb begin
    dreq    = dREN | dWEN;
    in_serv = (state_q != IDLE);
    own_req = 1'b0;
    if (state_q == ISERV) own_req = iREN;
    if (state_q == DSERV) own_req = dreq;
    access  = in_serv && own_req && (ramstate == RS_ACCESS);
    fault   = in_serv && own_req && !access &&
              ((ramstate == RS_ERROR) || (tmo_cnt_q == TMO_LIM));
    done    = access | fault;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      mem_err_q    <= mem_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    mem_err_d    = mem_err_q | fault;
    case (state_q)
      IDLE: begin
        if (dreq && !(iREN && (starve_cnt_q == STARVE_LIM))) begin
          state_d   = DSERV;
          tmo_cnt_d = '0;
          if (!iREN)
            starve_cnt_d = '0;
          else if (starve_cnt_q != STARVE_LIM)
            starve_cnt_d = starve_cnt_q + SC_W'(1);
        end else if (iREN) begin
          state_d      = ISERV;
          tmo_cnt_d    = '0;
          starve_cnt_d = '0;
        end
      end
      ISERV, DSERV: begin
        if (!own_req || done)
          state_d = IDLE;
        else
          tmo_cnt_d = tmo_cnt_q + TM_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM-side outputs follow the live requester inputs; everything is forced quiet while RST is high.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = iREN;
    dwait    = dreq;
    if (!RST) begin
      case (state_q)
        ISERV: begin
          if (iREN) begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
          end
          if (done) iwait = 1'b0;
          if (access) iload = ramload;
        end
        DSERV: begin
          if (dreq) begin
            ramaddr = daddr;
            if (dWEN) begin
              ramWEN   = 1'b1;
              ramstore = dstore;
            end else begin
              ramREN = 1'b1;
            end
          end
          if (done) dwait = 1'b0;
          if (access && !dWEN) dload = ramload;
        end
        default: ;
      endcase
    end
  end

  assign mem_err = mem_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single fetch, contention, starvation, timeout, abort, reset and ERROR.
module tb_mem_arbiter;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        mem_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(255)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks run 1ns later, well away from either edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic early;
    logic is_i;
    RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    tick(); tick();

    // Reset state; waits stay combinational during reset
    ramload = 32'hFFFF_FFFF; #1;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_iload", iload, 0);
    chk("rst_mem_err", mem_err, 0);
    iREN = 1'b1; dWEN = 1'b1; #1;
    chk("rst_iwait_follows", iwait, 1);
    chk("rst_dwait_follows", dwait, 1);
    chk("rst_ramWEN_low", ramWEN, 0);
    iREN = 1'b0; dWEN = 1'b0;
    tick();
    RST = 1'b0;

    // I only: grant, two BUSY, ACCESS
    iREN = 1'b1; iaddr = 32'h40; ramstate = FREE; #1;
    chk("i_idle_ramREN", ramREN, 0);
    chk("i_idle_iwait", iwait, 1);
    tick();
    ramstate = BUSY; #1;
    chk("i_serv_ramREN", ramREN, 1);
    chk("i_serv_ramaddr", ramaddr, 32'h40);
    chk("i_busy1_iwait", iwait, 1);
    tick();
    #1;
    chk("i_busy2_iwait", iwait, 1);
    tick();
    ramstate = ACCESS; ramload = 32'h8C01_0004; #1;
    chk("i_acc_iwait", iwait, 0);
    chk("i_acc_iload", iload, 32'h8C01_0004);
    tick();
    iREN = 1'b0; ramstate = ACCESS; #1;
    chk("i_after_idle_ramREN", ramREN, 0);
    chk("i_after_iload", iload, 0);
    tick();

    // Contention: D write wins, write beats read, I follows after one IDLE cycle
    iREN = 1'b1; iaddr = 32'h40; dWEN = 1'b1; dREN = 1'b1;
    daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = FREE; #1;
    chk("c_idle_iwait", iwait, 1);
    chk("c_idle_dwait", dwait, 1);
    tick();
    ramstate = BUSY; #1;
    chk("c_ramWEN", ramWEN, 1);
    chk("c_ramREN", ramREN, 0);
    chk("c_ramaddr", ramaddr, 32'h100);
    chk("c_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("c_iwait_held", iwait, 1);
    tick();
    ramstate = ACCESS; ramload = 32'h5555_5555; #1;
    chk("c_acc_dwait", dwait, 0);
    chk("c_acc_dload_write", dload, 0);
    chk("c_acc_iwait", iwait, 1);
    tick();
    dWEN = 1'b0; dREN = 1'b0; ramstate = FREE; #1;
    chk("c_gap_ramREN", ramREN, 0);
    chk("c_gap_ramWEN", ramWEN, 0);
    tick();
    ramstate = ACCESS; ramload = 32'h1111_1111; #1;
    chk("c_i_ramaddr", ramaddr, 32'h40);
    chk("c_i_iwait", iwait, 0);
    chk("c_i_iload", iload, 32'h1111_1111);
    tick();
    iREN = 1'b0; ramstate = FREE;
    tick();

    // Starvation: expected grant order D,D,D,D,I,D,D,D,D,I
    iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h200;
    for (int g = 0; g < 10; g++) begin
      is_i = (g == 4) || (g == 9);
      ramstate = FREE; #1;
      chk($sformatf("s%0d_idle_ramREN", g), ramREN, 0);
      tick();
      ramstate = BUSY; #1;
      chk($sformatf("s%0d_grant_addr", g), ramaddr, is_i ? 64'h40 : 64'h200);
      tick();
      ramstate = ACCESS; ramload = 32'h1000 + g; #1;
      chk($sformatf("s%0d_owner_wait", g), is_i ? iwait : dwait, 0);
      chk($sformatf("s%0d_other_wait", g), is_i ? dwait : iwait, 1);
      tick();
    end
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    tick();

    // Timeout: RAM stuck BUSY, release on the 256th service cycle
    dREN = 1'b1; daddr = 32'h300; ramstate = BUSY; ramload = 32'hAAAA_AAAA; #1;
    tick();
    early = 1'b0;
    for (int c = 0; c < 255; c++) begin
      if (dwait !== 1'b1 || mem_err !== 1'b0) early = 1'b1;
      tick();
    end
    chk("t_no_early_release", early, 0);
    chk("t_dwait", dwait, 0);
    chk("t_dload", dload, 0);
    tick();
    #1;
    chk("t_mem_err_set", mem_err, 1);
    chk("t_idle_dwait", dwait, 1);
    chk("t_idle_ramREN", ramREN, 0);
    dREN = 1'b0;
    tick();
    tick();
    chk("t_mem_err_sticky", mem_err, 1);

    // Abort: D drops after one BUSY cycle; ACCESS in IDLE is ignored
    dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
    tick();
    #1;
    chk("a_busy_ramREN", ramREN, 1);
    chk("a_busy_dwait", dwait, 1);
    tick();
    dREN = 1'b0; #1;
    chk("a_drop_ramREN", ramREN, 0);
    chk("a_drop_dwait", dwait, 0);
    tick();
    dREN = 1'b1; ramstate = ACCESS; ramload = 32'h7777_7777; #1;
    chk("a_idle_ramREN", ramREN, 0);
    chk("a_idle_dwait", dwait, 1);
    chk("a_idle_dload", dload, 0);
    dREN = 1'b0;
    tick();

    // Reset mid-ISERV clears mem_err and drops enables immediately
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
    tick();
    #1;
    chk("r_serv_ramREN", ramREN, 1);
    RST = 1'b1; #1;
    chk("r_rst_ramREN", ramREN, 0);
    chk("r_rst_iwait", iwait, 1);
    tick();
    RST = 1'b0; iREN = 1'b0; #1;
    chk("r_mem_err_clr", mem_err, 0);
    chk("r_idle_ramREN", ramREN, 0);
    tick();

    // ERROR status during ISERV
    iREN = 1'b1; ramstate = FREE;
    tick();
    ramstate = ERROR; ramload = 32'h1234_5678; #1;
    chk("e_iwait", iwait, 0);
    chk("e_iload", iload, 0);
    tick();
    ramstate = FREE; #1;
    chk("e_mem_err", mem_err, 1);
    chk("e_idle_iwait", iwait, 1);
    chk("e_idle_ramREN", ramREN, 0);
    iREN = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
